// File: rtl/proj_index_sequencer.sv
// Multi-buffer index sequencer: walks index 0..len over buffers 0..num, with
// stall, abort and single-shot or continuous operation.
module proj_index_sequencer #(
    parameter  int IDX_W       = 8,
    parameter  int NUM_BUFFERS = 4,
    localparam int BUF_W       = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic [IDX_W-1:0] in_len,
    input  logic [BUF_W-1:0] in_num_buf,
    input  logic             in_mode,
    input  logic             in_stall,
    input  logic             in_abort,
    output logic [IDX_W-1:0] index,
    output logic [BUF_W-1:0] buf_sel,
    output logic             index_valid,
    output logic             finished_count,
    output logic             finished_all,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: index/buf_sel are consumed on every cycle index_valid is high;
    // there is no back-pressure other than in_stall, which withholds valid.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [BUF_W-1:0] num_q, num_d;
    logic             mode_q, mode_d;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            num_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        buf_d   = buf_q;
        len_d   = len_q;
        num_d   = num_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                index_d = '0;
                buf_d   = '0;
                if (in_start) begin
                    len_d  = in_len;
                    mode_d = in_mode;
                    // A buffer count beyond the physical buffers collapses to the last one.
                    if (int'(in_num_buf) > NUM_BUFFERS - 1)
                        num_d = BUF_W'(NUM_BUFFERS - 1);
                    else
                        num_d = in_num_buf;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_abort) begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    buf_d   = '0;
                end else if (!in_stall) begin
                    if (index_q < len_q) begin
                        index_d = index_q + IDX_W'(1);
                    end else begin
                        index_d = '0;
                        if (buf_q < num_q) begin
                            buf_d = buf_q + BUF_W'(1);
                        end else begin
                            buf_d = '0;
                            if (!mode_q)
                                state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                index_d = '0;
                buf_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                index_d = '0;
                buf_d   = '0;
            end
        endcase
    end

    always_comb begin
        index          = index_q;
        buf_sel        = buf_q;
        index_valid    = (state_q == ST_RUN) && !in_stall;
        finished_count = index_valid && (index_q == len_q);
        finished_all   = finished_count && (buf_q == num_q);
        busy           = (state_q == ST_RUN) || (state_q == ST_DONE);
        done           = (state_q == ST_DONE);
        state_dbg      = state_q;
    end

endmodule

// File: tb/tb_proj_index_sequencer.sv
// Scoreboard bench for proj_index_sequencer: drivers push expected output
// records, a negedge monitor pops and compares each valid/done cycle.
module tb_proj_index_sequencer;

  localparam int IDX_W = 8;
  localparam int NUM_BUFFERS = 4;
  localparam int BUF_W = 2;
  localparam int REC_W = 1 + IDX_W + BUF_W + 2;

  logic             in_clk = 1'b0;
  logic             in_rst;
  logic             in_start;
  logic [IDX_W-1:0] in_len;
  logic [BUF_W-1:0] in_num_buf;
  logic             in_mode;
  logic             in_stall;
  logic             in_abort;
  logic [IDX_W-1:0] index;
  logic [BUF_W-1:0] buf_sel;
  logic             index_valid;
  logic             finished_count;
  logic             finished_all;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  int total = 0;
  int bad = 0;
  logic [REC_W-1:0] exp_q[$];

  proj_index_sequencer #(.IDX_W(IDX_W), .NUM_BUFFERS(NUM_BUFFERS)) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_start(in_start),
    .in_len(in_len),
    .in_num_buf(in_num_buf),
    .in_mode(in_mode),
    .in_stall(in_stall),
    .in_abort(in_abort),
    .index(index),
    .buf_sel(buf_sel),
    .index_valid(index_valid),
    .finished_count(finished_count),
    .finished_all(finished_all),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 in_clk = ~in_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input bit d, input int i, input int b,
                                          input bit fc, input bit fa);
    return {d, IDX_W'(i), BUF_W'(b), fc, fa};
  endfunction

  // Expected records for one complete single-shot run, ending with the done cycle.
  task automatic push_single(input int len, input int num);
    for (int b = 0; b <= num; b++)
      for (int i = 0; i <= len; i++)
        exp_q.push_back(mk(1'b0, i, b, i == len, (i == len) && (b == num)));
    exp_q.push_back(mk(1'b1, 0, 0, 1'b0, 1'b0));
  endtask

  // Returns one tick after the edge that accepted the start (first run cycle).
  task automatic start_run(input int len, input int num, input bit mode);
    @(posedge in_clk);
    #1;
    in_len = IDX_W'(len);
    in_num_buf = BUF_W'(num);
    in_mode = mode;
    in_start = 1'b1;
    @(posedge in_clk);
    #1;
    in_start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cycle);
    int cyc = 0;
    bit seen = 1'b0;
    while (cyc < 2000 && !seen) begin
      @(negedge in_clk);
      cyc++;
      check("busy_in_run", busy, 1);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    if (seen) check("done_cycle", cyc, exp_cycle);
  endtask

  task automatic expect_idle(input int cycles);
    repeat (cycles) begin
      @(negedge in_clk);
      check("idle_valid", index_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_index", index, 0);
      check("idle_buf", buf_sel, 0);
    end
  endtask

  // monitor
  always @(negedge in_clk) begin
    if (!in_rst) begin
      if (index_valid || done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got idx=%0d buf=%0d done=%0b expected none at %0t",
                   index, buf_sel, done, $time);
        end else begin
          check("output_rec", {done, index, buf_sel, finished_count, finished_all},
                exp_q.pop_front());
        end
      end else begin
        check("fin_gated", {finished_count, finished_all}, 0);
      end
    end
  end

  logic [IDX_W-1:0] t1_idx[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [BUF_W-1:0] t1_buf[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic             t1_fc[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic             t1_fa[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    in_rst = 1'b1;
    in_start = 1'b0;
    in_len = '0;
    in_num_buf = '0;
    in_mode = 1'b0;
    in_stall = 1'b0;
    in_abort = 1'b0;
    #1;
    check("rst_index", index, 0);
    check("rst_buf", buf_sel, 0);
    check("rst_valid", index_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fin", {finished_count, finished_all}, 0);
    #12;
    in_rst = 1'b0;

    // 1: len=3, num=1, single run from a directed table
    for (int k = 0; k < 8; k++) exp_q.push_back(mk(1'b0, t1_idx[k], t1_buf[k], t1_fc[k], t1_fa[k]));
    exp_q.push_back(mk(1'b1, 0, 0, 1'b0, 1'b0));
    start_run(3, 1, 1'b0);
    wait_done(9);
    expect_idle(2);

    // 2: same run with stall over cycles 3..5
    push_single(3, 1);
    start_run(3, 1, 1'b0);
    fork
      begin
        repeat (2) @(posedge in_clk);
        #1 in_stall = 1'b1;
        @(negedge in_clk);
        check("stall_index", index, 2);
        check("stall_valid", index_valid, 0);
        check("stall_fin", finished_count, 0);
        repeat (3) @(posedge in_clk);
        #1 in_stall = 1'b0;
      end
      wait_done(12);
    join
    expect_idle(1);

    // 3: len=0, four buffers, continuous, aborted at buf_sel=2
    for (int k = 0; k <= 10; k++) exp_q.push_back(mk(1'b0, 0, k % 4, 1'b1, (k % 4) == 3));
    start_run(0, 3, 1'b1);
    repeat (10) @(posedge in_clk);
    #1 in_abort = 1'b1;
    @(posedge in_clk);
    #1 in_abort = 1'b0;
    expect_idle(3);
    check("abort_q_empty", exp_q.size(), 0);

    // 4: num_buf 7 collapses to 3; len=255 wraps into the next buffer
    push_single(255, 3);
    start_run(255, 7, 1'b0);
    wait_done(1025);
    expect_idle(1);

    // 5: start while busy ignored, start in done cycle ignored, then accepted
    push_single(2, 1);
    start_run(2, 1, 1'b0);
    fork
      begin
        repeat (2) @(posedge in_clk);
        #1;
        in_len = 8'd1;
        in_num_buf = 2'd0;
        in_mode = 1'b1;
        in_start = 1'b1;
        @(posedge in_clk);
        #1 in_start = 1'b0;
      end
      wait_done(7);
    join
    in_start = 1'b1;
    @(posedge in_clk);
    #1 in_start = 1'b0;
    expect_idle(3);
    push_single(1, 0);
    start_run(1, 0, 1'b0);
    wait_done(3);
    expect_idle(1);

    // 6: async reset between edges at index=5, buf_sel=1
    for (int k = 0; k <= 12; k++) exp_q.push_back(mk(1'b0, k % 8, k / 8, (k % 8) == 7, 1'b0));
    start_run(7, 1, 1'b0);
    repeat (13) @(posedge in_clk);
    #1;
    check("pre_rst_index", index, 5);
    check("pre_rst_buf", buf_sel, 1);
    #1 in_rst = 1'b1;
    #1;
    check("async_index", index, 0);
    check("async_buf", buf_sel, 0);
    check("async_valid", index_valid, 0);
    check("async_busy", busy, 0);
    @(posedge in_clk);
    #1 in_rst = 1'b0;
    expect_idle(3);
    check("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proj_index_sequencer.md
Name: proj_index_sequencer

Overview:
- Programmable multi-buffer index generator.
- Walks an index 0..len over each of up to NUM_BUFFERS feature-map buffers in turn, and reports which buffer is active.
- Flags end-of-buffer and end-of-run, and supports stall, abort, and single-shot or continuous operation.
- Drives address and sequencing for FM buffer sort/fill logic in place of a fixed free-running counter.

Parameters:
IDX_W, 8, index width; maximum buffer length is 2^IDX_W.
NUM_BUFFERS, 4, number of FM buffers sequenced; must be >= 1.
BUF_W, derived as max(1, clog2(NUM_BUFFERS)), buffer-select width (localparam, not overridable).

Ports:
in_clk  input  1  clock, rising edge.
in_rst  input  1  reset, asynchronous, active-high.
in_start  input  1  start request; sampled only in IDLE.
in_len  input  IDX_W  last index per buffer (buffer length minus 1); latched on accepted start.
in_num_buf  input  BUF_W  last buffer number (count minus 1); latched on start, clamped to NUM_BUFFERS-1.
in_mode  input  1  latched on start; 0 = single run, 1 = continuous.
in_stall  input  1  holds index/buffer, deasserts index_valid.
in_abort  input  1  terminates run, returns to IDLE, no done pulse.
index  output  IDX_W  current index (registered).
buf_sel  output  BUF_W  current buffer (registered).
index_valid  output  1  index/buf_sel are live this cycle.
finished_count  output  1  valid cycle carrying last index of a buffer.
finished_all  output  1  valid cycle carrying last index of last buffer.
busy  output  1  state is RUN or DONE.
done  output  1  one-cycle pulse after single run completes.

Behaviour:
- Reset (async, any state): state = IDLE. index, buf_sel, latched len/num/mode = 0. All 1-bit outputs = 0.
- States:
  - IDLE: index = 0, buf_sel = 0, busy = 0. in_start = 1 → latch in_len, min(in_num_buf, NUM_BUFFERS-1), in_mode; go to RUN.
  - RUN: index_valid = ~in_stall. A cycle with index_valid = 1 is an "advance".
  - DONE: done = 1, busy = 1, index_valid = 0; unconditionally go to IDLE next cycle.
- Latency: start accepted in cycle N → index 0, buf_sel 0, index_valid = 1 in cycle N+1 (if not stalled).
- finished_count = index_valid & (index == len_q). finished_all = finished_count & (buf_sel == num_q). Both combinational from registered state.
- On advance:
  - index < len_q: index + 1.
  - Otherwise index → 0, and:
    - buf_sel < num_q: buf_sel + 1.
    - Otherwise buf_sel → 0; mode 0 → DONE, mode 1 → stay in RUN (wrap).
- Stall: index and buf_sel hold, finished_* = 0, no state change. Stall in IDLE or DONE has no effect.
- Abort in RUN: highest priority, beats advance and stall. Next cycle is IDLE, index = buf_sel = 0, no done pulse. Abort is ignored in IDLE and DONE.
- in_start while busy: ignored; new inputs are not latched.
- Boundary cases:
  - len_q = 0: every advance is finished_count.
  - len_q = 2^IDX_W - 1: index reaches all-ones, then wraps to 0 with no overflow.
- Continuous mode leaves RUN only via abort or reset.
- in_len, in_num_buf and in_mode changing during RUN have no effect.
- Single-run total: (len_q+1)*(num_q+1) valid cycles. done occurs the cycle after the finished_all advance.
- Reset asserted mid-run: immediate IDLE, outputs zero. After release, the block waits for a new start.

Test Plan:
1. Reset, then start with len=3, num_buf=1, mode=0, no stall → index 0,1,2,3,0,1,2,3 over 8 cycles. buf_sel 0×4 then 1×4. finished_count at cycles 4 and 8; finished_all at cycle 8. done the next cycle, then IDLE; busy high from cycle 1 through the done cycle.
2. Same run with in_stall held high for cycles 3–5 → index holds at 2, index_valid = 0, no finished pulses. Sequence resumes at 2; done is delayed by exactly 3 cycles.
3. len=0, num_buf=3, mode=1 → finished_count every valid cycle. buf_sel cycles 0,1,2,3,0,…; finished_all every 4th cycle, no done. in_abort at buf_sel=2 → IDLE next cycle, outputs 0, no done.
4. num_buf=7 with NUM_BUFFERS=4 → clamped to 3; finished_all when buf_sel=3. IDX_W=8, len=255 → index 255 wraps to 0 with buf_sel+1.
5. in_start pulsed mid-run with different len → ignored; the run completes with the original len. Start asserted in the done cycle → ignored. Start asserted in IDLE afterwards → accepted.
6. Async in_rst asserted between clock edges mid-run (index=5, buf_sel=1) → outputs 0 immediately, before the next edge. After release: index_valid = 0 until a new start.
